// File: rtl/pkt_hdr_checker.sv
// Receive-side checker for test packets: parses metadata, Ethernet header, tx timestamp and
// sequence/slot beat, emits one latency/sequence result per good packet and keeps statistics.
module pkt_hdr_checker #(
  parameter string PLATFORM = "xilinx"
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cnt_rst,
  input  logic [47:0]  timestamp,
  input  logic [133:0] in_data,
  input  logic         in_data_wr,
  input  logic         in_data_valid,
  input  logic         in_data_valid_wr,
  output logic         out_result_wr,
  output logic [2:0]   out_flow_id,
  output logic [31:0]  out_seq,
  output logic         out_seq_ok,
  output logic [3:0]   out_slot_shift_cnt,
  output logic [8:0]   out_slot_ID,
  output logic [47:0]  out_latency,
  output logic [31:0]  out_rx_pkt_cnt,
  output logic [31:0]  out_seq_err_cnt,
  output logic [31:0]  out_fmt_err_cnt,
  output logic [31:0]  out_drop_cnt,
  output logic [47:0]  out_max_latency
);

  typedef enum logic [2:0] {IDLE, MD1, HDR1, HDR2, HDR3, HDR4, SEQ, TAIL} state_t;

  state_t      state;
  logic [11:0] pkt_len;
  logic [15:0] byte_cnt;
  logic [47:0] rx_ts, tx_ts;
  logic [2:0]  flow;
  logic [31:0] seq_r;
  logic [3:0]  shift_r;
  logic [8:0]  slot_r;
  logic [31:0] exp_seq [8];

  logic        unused;
  assign unused = ^{in_data, (PLATFORM == "xilinx")};

  logic        is_head, is_mid, is_tail, late, drop, len_ok, good, fmt_err;
  logic [15:0] cnt_tail;
  logic [31:0] seq_cur;
  logic [3:0]  shift_cur;
  logic [8:0]  slot_cur;
  logic [47:0] latency;
  logic        seq_ok;

  assign is_head  = in_data_wr && (in_data[133:132] == 2'b01);
  assign is_mid   = in_data_wr && (in_data[133:132] == 2'b11);
  assign is_tail  = in_data_wr && (in_data[133:132] == 2'b10);
  assign late     = (state == SEQ) || (state == TAIL);
  assign cnt_tail = byte_cnt + 16'd16 - {12'd0, in_data[131:128]};
  assign len_ok   = (cnt_tail == {4'd0, pkt_len});
  assign drop     = is_tail && late && in_data_valid_wr && !in_data_valid;
  assign good     = is_tail && late && !drop && len_ok;
  assign fmt_err  = (is_head && state != IDLE) ||
                    (is_tail && state != IDLE && !late) ||
                    (is_tail && late && !drop && !len_ok);

  // A 7-beat packet ends on the seq beat itself, so take the fields straight off the bus.
  assign seq_cur   = (state == SEQ) ? in_data[127:96] : seq_r;
  assign shift_cur = (state == SEQ) ? in_data[19:16]  : shift_r;
  assign slot_cur  = (state == SEQ) ? in_data[8:0]    : slot_r;
  assign latency   = rx_ts - tx_ts;
  assign seq_ok    = (seq_cur == exp_seq[flow]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      pkt_len            <= '0;
      byte_cnt           <= '0;
      rx_ts              <= '0;
      tx_ts              <= '0;
      flow               <= '0;
      seq_r              <= '0;
      shift_r            <= '0;
      slot_r             <= '0;
      out_result_wr      <= 1'b0;
      out_flow_id        <= '0;
      out_seq            <= '0;
      out_seq_ok         <= 1'b0;
      out_slot_shift_cnt <= '0;
      out_slot_ID        <= '0;
      out_latency        <= '0;
    end else begin
      out_result_wr <= 1'b0;
      if (is_head) begin
        state    <= MD1;
        rx_ts    <= timestamp;
        pkt_len  <= in_data[107:96];
        byte_cnt <= 16'd16;
      end else if (is_tail && state != IDLE) begin
        state <= IDLE;
      end else if (is_mid && state != IDLE) begin
        byte_cnt <= byte_cnt + 16'd16;
        if (state != TAIL) state <= state_t'(state + 3'd1);
        case (state)
          HDR1: flow <= in_data[82:80];
          HDR4: tx_ts <= in_data[47:0];
          SEQ: begin
            seq_r   <= in_data[127:96];
            shift_r <= in_data[19:16];
            slot_r  <= in_data[8:0];
          end
          default: ;
        endcase
      end
      if (good) begin
        out_result_wr      <= 1'b1;
        out_flow_id        <= flow;
        out_seq            <= seq_cur;
        out_seq_ok         <= seq_ok;
        out_slot_shift_cnt <= shift_cur;
        out_slot_ID        <= slot_cur;
        out_latency        <= latency;
      end
    end
  end

  // Statistics and expected-sequence table; cnt_rst overrides any same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_rx_pkt_cnt  <= '0;
      out_seq_err_cnt <= '0;
      out_fmt_err_cnt <= '0;
      out_drop_cnt    <= '0;
      out_max_latency <= '0;
      for (int i = 0; i < 8; i++) exp_seq[i] <= 32'd1;
    end else if (cnt_rst) begin
      out_rx_pkt_cnt  <= '0;
      out_seq_err_cnt <= '0;
      out_fmt_err_cnt <= '0;
      out_drop_cnt    <= '0;
      out_max_latency <= '0;
      for (int i = 0; i < 8; i++) exp_seq[i] <= 32'd1;
    end else begin
      if (fmt_err) out_fmt_err_cnt <= out_fmt_err_cnt + 32'd1;
      if (drop) out_drop_cnt <= out_drop_cnt + 32'd1;
      if (good) begin
        out_rx_pkt_cnt <= out_rx_pkt_cnt + 32'd1;
        if (!seq_ok) out_seq_err_cnt <= out_seq_err_cnt + 32'd1;
        exp_seq[flow] <= seq_cur + 32'd1;
        if (latency > out_max_latency) out_max_latency <= latency;
      end
    end
  end

endmodule

// File: doc/pkt_hdr_checker.md
# pkt_hdr_checker

Receive-side checker for the test packets produced by the packet header extension stage. It sits on the 134-bit packet bus from the FPGA OS side and parses each packet's metadata, Ethernet header, transmit timestamp and sequence/slot beat. It emits one latency/sequence result per well-formed packet and keeps aggregate statistics for the LCM.

## Interface
- PLATFORM, "xilinx", target vendor tag; no functional effect.
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- cnt_rst  in  1  synchronous clear of statistics and sequence table; active high.
- timestamp  in  48  local free-running time, same base as the transmit side.
- in_data  in  134  packet beat:
  - [133:132]: 01 = head, 11 = middle, 10 = tail.
  - [131:128]: invalid byte count, tail only.
  - [127:0]: data.
- in_data_wr  in  1  beat strobe.
- in_data_valid  in  1  packet keep (1) / discard (0).
- in_data_valid_wr  in  1  strobe for in_data_valid; asserted with the tail beat.
- out_result_wr  out  1  one-cycle result strobe.
- out_flow_id  out  3  flow index.
- out_seq  out  32  received sequence number.
- out_seq_ok  out  1  sequence matched expectation.
- out_slot_shift_cnt  out  4  slot shift count carried in the packet.
- out_slot_ID  out  9  slot ID carried in the packet.
- out_latency  out  48  rx minus tx timestamp.
- out_rx_pkt_cnt  out  32  results emitted.
- out_seq_err_cnt  out  32  sequence mismatches.
- out_fmt_err_cnt  out  32  malformed packets.
- out_drop_cnt  out  32  packets discarded via in_data_valid = 0.
- out_max_latency  out  48  largest out_latency since clear.

## Operation
- Beat layout, counting the head as beat 0:
  - Beat 0, head: [107:96] = total bytes L, which includes 32 metadata bytes.
  - Beat 1: metadata 2, ignored.
  - Beat 2: Ethernet header. Flow id = [82:80], the low 3 bits of the last DMAC byte.
  - Beats 3 and 4: ignored.
  - Beat 5: tx timestamp in [47:0].
  - Beat 6: seq in [127:96], slot_shift_cnt in [19:16], slot_ID in [8:0].
  - Beats 7 and later: padding.
- FSM states: IDLE, MD1, HDR1, HDR2, HDR3, HDR4, SEQ, TAIL.
  - A head beat in IDLE latches rx_ts = timestamp and L, sets byte_cnt = 16, and moves to MD1.
  - Each later beat advances one state. TAIL holds on middle beats.
  - Each middle beat adds 16 to byte_cnt. The tail beat adds 16 − [131:128].
- Tail handling:
  - Tail in SEQ or TAIL, in_data_valid_wr = 1, in_data_valid = 0: drop_cnt++, no result.
  - Otherwise, if byte_cnt (including the tail beat) ≠ L: fmt_err_cnt++, no result.
  - Otherwise: emit a result and go to IDLE.
- Tail before SEQ (beats 0–5 only): fmt_err_cnt++, go to IDLE.
- A head beat in any state other than IDLE:
  - fmt_err_cnt++.
  - The partial packet is abandoned.
  - The head is processed as the start of a new packet, moving to MD1.
- Middle or tail beats in IDLE are discarded silently.
- Sequence table: exp[0..7], 32 bits each, reset to 1.
  - On a result, out_seq_ok = (seq == exp[flow]).
  - If not ok: seq_err_cnt++.
  - exp[flow] = seq + 1 in both cases, modulo 2^32.
- Latency = rx_ts − tx_ts, modulo 2^48, so wrap is natural. out_max_latency updates when latency > max.
- Counters wrap modulo 2^32 with no saturation.
- cnt_rst = 1:
  - Clears all counters and out_max_latency.
  - Resets exp[] to 1.
  - Does not affect the FSM or result output.
  - A result in the same cycle is still emitted, but counters end at 0 and exp[] ends at 1.
- Beats arriving without in_data_wr are ignored. Gaps between beats are allowed.

## Timing
- Reset: every output is 0, the FSM is in IDLE, and exp[] = 1.
- Result fields and out_result_wr are registered, valid the cycle after the accepted tail beat. out_result_wr is high for exactly one cycle.
- Counters and out_max_latency update in that same cycle.
- fmt_err_cnt and drop_cnt update the cycle after the offending beat.
- No backpressure: a beat is accepted every cycle, including back-to-back packets where a head immediately follows a tail.
- Reset mid-packet discards the packet without counting it.

## Test plan
- Single packet:
  - Stimulus: L = 132, i.e. 9 beats with tail invalid = 12; flow 3; tx_ts = 0x1000; timestamp = 0x1500 at head; seq = 1; slot_ID = 0x1A5; shift = 2.
  - Response: one result with flow 3, seq 1, ok = 1, latency 0x500, slot 0x1A5/2; rx_pkt_cnt = 1; max = 0x500.
- Sequence gap:
  - Stimulus: flow 5 with seq 1, 2, then 4, back-to-back.
  - Response: ok = 1, 1, 0; seq_err_cnt = 1; next seq 5 gives ok = 1.
- Timestamp wrap:
  - Stimulus: tx_ts = 0xFFFF_FFFF_FFF0, rx_ts = 0x10.
  - Response: latency = 0x20.
- Malformed packets:
  - Stimulus 1: tail on beat 4. Response: fmt_err_cnt = 1, no result.
  - Stimulus 2: L = 132 but 10 beats delivered. Response: fmt_err_cnt = 2.
  - Stimulus 3: head injected at beat 3 of a packet. Response: fmt_err_cnt = 3; the following packet completes normally.
- Drop:
  - Stimulus: tail with in_data_valid_wr = 1, in_data_valid = 0.
  - Response: drop_cnt = 1, no result, exp[] unchanged.
- Clear collision:
  - Stimulus: cnt_rst asserted in the cycle a result is produced.
  - Response: result emitted; all counters and max = 0 next cycle; the next seq 1 on any flow gives ok = 1.
